// File: rtl/operand_fetch_if.sv
// Operand-fetch bundle: decoded request in, regfile read port, snooped writeback, operands out.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on the request side, out_valid/out_ready on the operand side.
interface operand_fetch_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 3
);
   // decoded request
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_rn;
   logic [ADDR_W-1:0]     req_rm;
   logic [1:0]            req_shift;
   logic [1:0]            req_op;
   // regfile read port (combinational read)
   logic [ADDR_W-1:0]     readnum;
   logic [DATA_WIDTH-1:0] rf_rdata;
   // regfile write port, snooped
   logic                  wb_write;
   logic [ADDR_W-1:0]     wb_writenum;
   logic [DATA_WIDTH-1:0] wb_data;
   // operands to execute
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_a;
   logic [DATA_WIDTH-1:0] out_b;
   logic [1:0]            out_op;

   // decoder / regfile / execute side
   modport master (
      output req_valid, req_rn, req_rm, req_shift, req_op,
      input  req_ready,
      input  readnum,
      output rf_rdata,
      output wb_write, wb_writenum, wb_data,
      input  out_valid, out_a, out_b, out_op,
      output out_ready
   );

   // operand-fetch stage side
   modport slave (
      input  req_valid, req_rn, req_rm, req_shift, req_op,
      output req_ready,
      output readnum,
      input  rf_rdata,
      input  wb_write, wb_writenum, wb_data,
      output out_valid, out_a, out_b, out_op,
      input  out_ready
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads A=R[rn] then B=shift(R[rm]) through one regfile port, presents both downstream.
// Latency: out_valid rises on the 3rd edge counting the accepting edge; one op per 4 cycles at best.
// Backpressure: req_ready only in IDLE; HOLD keeps operands stable until out_ready.
// Option: OPFETCH_BYPASS_EN forwards a same-cycle regfile write to the register being read.
module operand_fetch #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   operand_fetch_if.slave fetch
);

   typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     rn_q, rm_q;
   logic [1:0]            shift_q, op_q;
   logic [DATA_WIDTH-1:0] a_tmp_q;
   logic [DATA_WIDTH-1:0] out_a_q, out_b_q;
   logic [1:0]            out_op_q;
   logic [ADDR_W-1:0]     readnum_c;
   logic                  req_ready_c, out_valid_c;
   logic [DATA_WIDTH-1:0] fetch_data;

   // Width-preserving single-bit shift applied to operand B; nothing is carried out.
   function automatic logic [DATA_WIDTH-1:0] shift1(input logic [DATA_WIDTH-1:0] v,
                                                    input logic [1:0] s);
      logic [DATA_WIDTH-1:0] r;
      case (s)
         2'b01:   r = v << 1;
         2'b10:   r = v >> 1;
         2'b11:   r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

`ifdef OPFETCH_BYPASS_EN
   logic bypass_hit;
   // A write landing on the register being read this cycle wins over the stale read data.
   assign bypass_hit = fetch.wb_write && (fetch.wb_writenum == readnum_c) &&
                       ((state_q == READ_A) || (state_q == READ_B));
   assign fetch_data = bypass_hit ? fetch.wb_data : fetch.rf_rdata;
`else
   // Without forwarding the regfile's pre-write value is taken; the write port is not observed.
   assign fetch_data = fetch.rf_rdata;
   logic unused_wb;
   assign unused_wb = ^{fetch.wb_write, fetch.wb_writenum, fetch.wb_data};
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-state handshake / read-port outputs.
   always_comb begin
      state_d     = state_q;
      req_ready_c = 1'b0;
      out_valid_c = 1'b0;
      readnum_c   = '0;
      case (state_q)
         IDLE: begin
            req_ready_c = 1'b1;
            if (fetch.req_valid) state_d = READ_A;
         end
         READ_A: begin
            readnum_c = rn_q;
            state_d   = READ_B;
         end
         READ_B: begin
            readnum_c = rm_q;
            state_d   = HOLD;
         end
         HOLD: begin
            out_valid_c = 1'b1;
            if (fetch.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture, A staging, and a single update of all outputs when B lands, so the
   // previous operands stay visible until the new set is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rn_q     <= '0;
         rm_q     <= '0;
         shift_q  <= '0;
         op_q     <= '0;
         a_tmp_q  <= '0;
         out_a_q  <= '0;
         out_b_q  <= '0;
         out_op_q <= '0;
      end else begin
         if (state_q == IDLE && fetch.req_valid) begin
            rn_q    <= fetch.req_rn;
            rm_q    <= fetch.req_rm;
            shift_q <= fetch.req_shift;
            op_q    <= fetch.req_op;
         end
         if (state_q == READ_A) a_tmp_q <= fetch_data;
         if (state_q == READ_B) begin
            out_a_q  <= a_tmp_q;
            out_b_q  <= shift1(fetch_data, shift_q);
            out_op_q <= op_q;
         end
      end
   end

   assign fetch.req_ready = req_ready_c;
   assign fetch.readnum   = readnum_c;
   assign fetch.out_valid = out_valid_c;
   assign fetch.out_a     = out_a_q;
   assign fetch.out_b     = out_b_q;
   assign fetch.out_op    = out_op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch with a behavioural regfile (combinational read, clocked write).
// Expected operands come from a register-array model and arithmetic shift rules.
// Build with OPFETCH_BYPASS_EN defined to check the forwarding variant.
module tb_operand_fetch;
   localparam int DW = 16;
   localparam int AW = 3;
`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [DW-1:0] mdl    [8];
   logic [DW-1:0] rf_mem [8];

   operand_fetch_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) ofi ();

   operand_fetch #(.DATA_WIDTH(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fetch (ofi)
   );

   always #5 clk = ~clk;

   // regfile: clocked write, combinational read
   always @(posedge clk) if (ofi.wb_write) rf_mem[ofi.wb_writenum] <= ofi.wb_data;
   assign ofi.rf_rdata = rf_mem[ofi.readnum];

   // shift rules expressed as plain arithmetic on an unsigned 16-bit value
   function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] v, input logic [1:0] s);
      int unsigned x;
      x = 32'(v);
      case (s)
         2'b01:   return DW'((x * 2) % 65536);
         2'b10:   return DW'(x / 2);
         2'b11:   return DW'(x / 2 + ((x >= 32768) ? 32768 : 0));
         default: return v;
      endcase
   endfunction

   // regfile write through the write port; model follows once the edge has passed
   task automatic rf_write(input logic [2:0] n, input logic [DW-1:0] d);
      ofi.wb_write = 1'b1; ofi.wb_writenum = n; ofi.wb_data = d;
      @(posedge clk); #1;
      ofi.wb_write = 1'b0;
      mdl[n] = d;
   endtask

   // Drives one request from IDLE (called at posedge+1) and returns what was observed.
   // wp=1/2 issues a regfile write during the first/second read cycle; hold>0 stalls HOLD.
   task automatic run_op(input logic [2:0] rn, input logic [2:0] rm,
                         input logic [1:0] sh, input logic [1:0] op,
                         input int wp, input logic [2:0] wn, input logic [DW-1:0] wd,
                         input int hold,
                         output logic [DW-1:0] oa, output logic [DW-1:0] ob,
                         output logic [1:0] oo, output int lat,
                         output logic [2:0] rda, output logic [2:0] rdb,
                         output logic [2:0] rdh, output logic busy, output logic stable);
      busy = 1'b0; stable = 1'b1; oa = '0; ob = '0; oo = '0; rdh = '0;
      ofi.req_rn = rn; ofi.req_rm = rm; ofi.req_shift = sh; ofi.req_op = op;
      ofi.req_valid = 1'b1;
      @(posedge clk); #1;
      ofi.req_valid = 1'b0; lat = 1;
      rda = ofi.readnum; busy = busy | ofi.req_ready;
      if (wp == 1) begin ofi.wb_write = 1'b1; ofi.wb_writenum = wn; ofi.wb_data = wd; end
      @(posedge clk); #1;
      lat = 2;
      if (wp == 1) begin ofi.wb_write = 1'b0; mdl[wn] = wd; end
      rdb = ofi.readnum; busy = busy | ofi.req_ready;
      if (wp == 2) begin ofi.wb_write = 1'b1; ofi.wb_writenum = wn; ofi.wb_data = wd; end
      @(posedge clk); #1;
      lat = 3;
      if (wp == 2) begin ofi.wb_write = 1'b0; mdl[wn] = wd; end
      while (ofi.out_valid !== 1'b1 && lat < 16) begin
         @(posedge clk); #1;
         lat++;
      end
      if (ofi.out_valid === 1'b1) begin
         oa = ofi.out_a; ob = ofi.out_b; oo = ofi.out_op; rdh = ofi.readnum;
         busy = busy | ofi.req_ready;
         if (hold > 0) begin
            ofi.out_ready = 1'b0;
            ofi.req_rn = ~rn; ofi.req_rm = ~rm; ofi.req_shift = ~sh; ofi.req_op = ~op;
            ofi.req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
               @(posedge clk); #1;
               if (ofi.out_valid !== 1'b1 || ofi.out_a !== oa || ofi.out_b !== ob ||
                   ofi.out_op !== oo) stable = 1'b0;
               busy = busy | ofi.req_ready;
            end
            ofi.req_valid = 1'b0;
            ofi.out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   logic [DW-1:0] oa, ob;
   logic [1:0]    oo;
   int            lat;
   logic [2:0]    rda, rdb, rdh;
   logic          busy, stable;

   task automatic test_reset();
      rst_n = 1'b0;
      ofi.req_valid = 1'b0; ofi.req_rn = '0; ofi.req_rm = '0; ofi.req_shift = '0; ofi.req_op = '0;
      ofi.wb_write = 1'b0; ofi.wb_writenum = '0; ofi.wb_data = '0; ofi.out_ready = 1'b1;
      #12;
      n_cmp++; if (ofi.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", ofi.out_valid); end
      n_cmp++; if (ofi.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got %b want 1", ofi.req_ready); end
      n_cmp++; if (ofi.readnum !== 3'd0) begin n_bad++; $display("FAIL rst_readnum got %0d want 0", ofi.readnum); end
      n_cmp++; if ({ofi.out_a, ofi.out_b, ofi.out_op} !== '0) begin n_bad++; $display("FAIL rst_outputs got a=%h b=%h op=%0d want 0", ofi.out_a, ofi.out_b, ofi.out_op); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 8; r++) rf_write(3'(r), DW'($urandom));
      rf_write(3'd4, 16'd42);
      rf_write(3'd2, 16'h8001);
   endtask

   task automatic test_basic();
      run_op(3'd4, 3'd2, 2'b00, 2'd2, 0, 3'd0, '0, 0, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL t1_latency got %0d want 3", lat); end
      n_cmp++; if (oa !== 16'd42) begin n_bad++; $display("FAIL t1_out_a got %h want %h", oa, 16'd42); end
      n_cmp++; if (ob !== 16'h8001) begin n_bad++; $display("FAIL t1_out_b got %h want 8001", ob); end
      n_cmp++; if (oo !== 2'd2) begin n_bad++; $display("FAIL t1_out_op got %0d want 2", oo); end
      n_cmp++; if ({rda, rdb, rdh} !== {3'd4, 3'd2, 3'd0}) begin n_bad++; $display("FAIL t1_readnum got %0d/%0d/%0d want 4/2/0", rda, rdb, rdh); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_req_ready_busy got %b want 0", busy); end
      n_cmp++; if (ofi.out_valid !== 1'b0 || ofi.req_ready !== 1'b1) begin n_bad++; $display("FAIL t1_after_xfer got valid=%b ready=%b want 0/1", ofi.out_valid, ofi.req_ready); end
      n_cmp++; if (ofi.out_a !== 16'd42 || ofi.out_b !== 16'h8001) begin n_bad++; $display("FAIL t1_hold_after got a=%h b=%h want 002a/8001", ofi.out_a, ofi.out_b); end
   endtask

   task automatic test_shifts();
      logic [DW-1:0] exp_b [3];
      exp_b[0] = 16'h0002; exp_b[1] = 16'h4000; exp_b[2] = 16'hC000;
      for (int s = 1; s <= 3; s++) begin
         run_op(3'd4, 3'd2, 2'(s), 2'(s), 0, 3'd0, '0, 0, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
         n_cmp++; if (ob !== exp_b[s-1] || oa !== 16'd42 || oo !== 2'(s)) begin n_bad++; $display("FAIL t2_shift%0d got a=%h b=%h op=%0d want 002a/%h/%0d", s, oa, ob, oo, exp_b[s-1], s); end
      end
   endtask

   task automatic test_backpressure();
      run_op(3'd4, 3'd2, 2'b11, 2'd1, 0, 3'd0, '0, 5, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
      n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL t3_stable got %b want 1", stable); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t3_req_ready_busy got %b want 0", busy); end
      n_cmp++; if (oa !== 16'd42 || ob !== 16'hC000 || oo !== 2'd1) begin n_bad++; $display("FAIL t3_operands got a=%h b=%h op=%0d want 002a/c000/1", oa, ob, oo); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (ofi.out_valid !== 1'b0 || ofi.req_ready !== 1'b1) begin n_bad++; $display("FAIL t3_ignored_req cyc%0d got valid=%b ready=%b want 0/1", i, ofi.out_valid, ofi.req_ready); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      ofi.req_rn = 3'd2; ofi.req_rm = 3'd4; ofi.req_shift = 2'b00; ofi.req_op = 2'd3;
      ofi.req_valid = 1'b1;
      @(posedge clk); #1;
      ofi.req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ofi.out_valid !== 1'b0 || ofi.req_ready !== 1'b1) begin n_bad++; $display("FAIL t4_handshake got valid=%b ready=%b want 0/1", ofi.out_valid, ofi.req_ready); end
      n_cmp++; if (ofi.out_a !== '0 || ofi.out_b !== '0 || ofi.out_op !== '0) begin n_bad++; $display("FAIL t4_outputs got a=%h b=%h op=%0d want 0", ofi.out_a, ofi.out_b, ofi.out_op); end
      n_cmp++; if (ofi.readnum !== 3'd0) begin n_bad++; $display("FAIL t4_readnum got %0d want 0", ofi.readnum); end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(3'd2, 3'd4, 2'b00, 2'd3, 0, 3'd0, '0, 0, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
      n_cmp++; if (lat !== 3 || oa !== 16'h8001 || ob !== 16'd42 || oo !== 2'd3) begin n_bad++; $display("FAIL t4_refetch got lat=%0d a=%h b=%h op=%0d want 3/8001/002a/3", lat, oa, ob, oo); end
   endtask

   task automatic test_write_hazard();
      logic [DW-1:0] exp_a;
      exp_a = BYP ? 16'd7 : 16'd42;
      run_op(3'd4, 3'd2, 2'b00, 2'd0, 1, 3'd4, 16'd7, 0, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
      n_cmp++; if (oa !== exp_a || ob !== 16'h8001) begin n_bad++; $display("FAIL t5_write_in_read_a got a=%h b=%h want %h/8001", oa, ob, exp_a); end
      run_op(3'd4, 3'd0, 2'b00, 2'd0, 0, 3'd0, '0, 0, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
      n_cmp++; if (oa !== 16'd7) begin n_bad++; $display("FAIL t5_written_value got %h want 0007", oa); end
   endtask

   task automatic test_same_reg();
      rf_write(3'd4, 16'hFFFE);
      run_op(3'd4, 3'd4, 2'b11, 2'd1, 0, 3'd0, '0, 0, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
      n_cmp++; if (oa !== 16'hFFFE || ob !== 16'hFFFF) begin n_bad++; $display("FAIL t6_same_reg got a=%h b=%h want fffe/ffff", oa, ob); end
      n_cmp++; if ({rda, rdb} !== {3'd4, 3'd4}) begin n_bad++; $display("FAIL t6_readnum got %0d/%0d want 4/4", rda, rdb); end
   endtask

   task automatic test_random();
      logic [2:0]    rn, rm, wn;
      logic [1:0]    sh, op;
      logic [DW-1:0] wd, exp_a, exp_b;
      logic [DW-1:0] mid [8];
      int            wp, hold;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) rf_write(3'($urandom_range(0, 7)), DW'($urandom));
         rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7));
         sh = 2'($urandom_range(0, 3)); op = 2'($urandom_range(0, 3));
         wp = int'($urandom_range(0, 2)); wn = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) wn = (wp == 2) ? rm : rn;
         wd = DW'($urandom); hold = int'($urandom_range(0, 3));
         // A sees the register file before any write in its own cycle (unless forwarded);
         // B sees the file after a write issued during the A read.
         exp_a = (wp == 1 && wn == rn && BYP) ? wd : mdl[rn];
         for (int r = 0; r < 8; r++) mid[r] = mdl[r];
         if (wp == 1) mid[wn] = wd;
         exp_b = (wp == 2 && wn == rm && BYP) ? wd : mid[rm];
         exp_b = ref_shift(exp_b, sh);
         run_op(rn, rm, sh, op, wp, wn, wd, hold, oa, ob, oo, lat, rda, rdb, rdh, busy, stable);
         n_cmp++; if (lat !== 3 || oa !== exp_a || ob !== exp_b || oo !== op || stable !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd%0d got lat=%0d a=%h b=%h op=%0d stable=%b want 3/%h/%h/%0d/1", it, lat, oa, ob, oo, stable, exp_a, exp_b, op);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shifts();
      test_backpressure();
      test_reset_mid();
      test_write_hazard();
      test_same_reg();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
